// File: rtl/st7735_spi_tx.sv
// st7735_spi_tx: SPI mode-0 master transmitter for the ST7735R display link.
// Ports:
//   i_spi_clk        block clock; SCK runs at half this rate
//   i_rst_n          asynchronous active-low reset
//   i_byte/i_dc/i_last/i_valid, o_ready   byte handshake into a 1-entry holding register
//   o_spi_sck/o_spi_cs/o_spi_mosi/o_dc    registered SPI lines (SCK idle low, CS active-low)
//   o_busy           FSM active or a byte is pending
//   o_byte_done_pls  one-cycle pulse as a byte's 8th SCK high phase completes
module st7735_spi_tx #(
  parameter int CS_SETUP_CYC = 1,
  parameter int CS_HOLD_CYC  = 1,
  parameter int CS_GAP_CYC   = 2
) (
  input  logic       i_spi_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_dc,
  input  logic       i_last,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_spi_sck,
  output logic       o_spi_cs,
  output logic       o_spi_mosi,
  output logic       o_dc,
  output logic       o_busy,
  output logic       o_byte_done_pls
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;
  localparam logic [7:0] SETUP_N = 8'(CS_SETUP_CYC - 1);
  localparam logic [7:0] HOLD_N  = 8'(CS_HOLD_CYC - 1);
  localparam logic [7:0] GAP_N   = 8'(CS_GAP_CYC - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, sh_q, sh_d, hold_byte_q, hold_byte_d;
  logic [3:0] ph_q, ph_d;
  logic last_q, last_d, hold_dc_q, hold_dc_d, hold_last_q, hold_last_d, hold_full_q, hold_full_d;
  logic sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d, dc_q, dc_d, done_q, done_d;
  logic hs, bit_end, take, shift;
  // ph_q walks 16 half-bits per byte: even = SCK low (MOSI settles), odd = SCK high
  assign hs      = i_valid & ~hold_full_q;
  assign bit_end = (state_q == SHIFT) && (ph_q == 4'hF);
  assign take    = hold_full_q && ((state_q == IDLE) || (state_q == WAIT) || (bit_end && !last_q));
  // advance to the next bit only inside the byte so MOSI holds after bit 0
  assign shift   = (state_q == SHIFT) && ph_q[0] && (ph_q != 4'hF);
  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ph_q        <= '0;
      sh_q        <= '0;
      last_q      <= 1'b0;
      hold_byte_q <= '0;
      hold_dc_q   <= 1'b0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      dc_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      sh_q        <= sh_d;
      last_q      <= last_d;
      hold_byte_q <= hold_byte_d;
      hold_dc_q   <= hold_dc_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      dc_q        <= dc_d;
      done_q      <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE:  if (hold_full_q) begin state_d = SETUP; cnt_d = '0; end
      SETUP: if (cnt_q == SETUP_N) begin state_d = SHIFT; cnt_d = '0; ph_d = '0; end else cnt_d = cnt_q + 8'd1;
      SHIFT: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'hF) begin
          state_d = last_q ? HOLD : hold_full_q ? SHIFT : WAIT;
          cnt_d   = '0;
        end
      end
      WAIT:  if (hold_full_q) begin state_d = SHIFT; ph_d = '0; end
      HOLD:  if (cnt_q == HOLD_N) begin state_d = GAP; cnt_d = '0; end else cnt_d = cnt_q + 8'd1;
      GAP:   if (cnt_q == GAP_N) begin state_d = IDLE; cnt_d = '0; end else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    hold_full_d = hs | (hold_full_q & ~take);
    hold_byte_d = hs ? i_byte : hold_byte_q;
    hold_dc_d   = hs ? i_dc : hold_dc_q;
    hold_last_d = hs ? i_last : hold_last_q;
    sh_d        = take ? hold_byte_q : shift ? {sh_q[6:0], 1'b0} : sh_q;
    mosi_d      = take ? hold_byte_q[7] : shift ? sh_q[6] : mosi_q;
    dc_d        = take ? hold_dc_q : dc_q;
    last_d      = take ? hold_last_q : last_q;
    sck_d       = (state_q == SHIFT) && !ph_q[0];
    cs_d        = (state_q == IDLE && hold_full_q) ? 1'b0 : (state_q == HOLD && cnt_q == HOLD_N) ? 1'b1 : cs_q;
    done_d      = bit_end;
    o_ready         = ~hold_full_q;
    o_busy          = (state_q != IDLE) || hold_full_q;
    o_spi_sck       = sck_q;
    o_spi_cs        = cs_q;
    o_spi_mosi      = mosi_q;
    o_dc            = dc_q;
    o_byte_done_pls = done_q;
  end
endmodule
